icmp_reply_framer: RTL and testbench



---
 rtl/eth_pkg.sv | 27 ++
 rtl/ipv4_hdr_csum.sv | 25 ++
 rtl/icmp_reply_framer.sv | 149 ++++++++++++++
 tb/tb_icmp_reply_framer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared IPv4 constants, framer state encoding and the 16-bit ones' complement fold
// used by the ICMP/UDP transmit framers.
package eth_pkg;

    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TOS         = 8'h00;
    localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;
    localparam logic [7:0]  IP_PROTO_ICMP  = 8'h01;
    localparam logic [15:0] IPV4_HDR_BYTES = 16'd20;

    typedef enum logic [2:0] {
        StIdle,
        StCsum,
        StFold,
        StHdr,
        StPay,
        StDone
    } framer_state_e;

    // Two end-around-carry steps suffice: a 20-bit sum folds to at most 17 bits once.
    function automatic logic [15:0] ones_fold16(input logic [19:0] sum);
        logic [16:0] s1;
        s1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
        return s1[15:0] + {15'b0, s1[16]};
    endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// Combinational 20-bit sum of the nine non-checksum halfwords of an option-less IPv4
// header (DF set, fragment offset 0, protocol ICMP).
module ipv4_hdr_csum
    import eth_pkg::*;
#(
    parameter logic [7:0] Ttl = 8'd64
) (
    input  logic [15:0] total_len_i,
    input  logic [15:0] ident_i,
    input  logic [31:0] src_ip_i,
    input  logic [31:0] dst_ip_i,
    output logic [19:0] sum_o
);

    assign sum_o = 20'({IP_VER_IHL, IP_TOS})
                 + 20'(total_len_i)
                 + 20'(ident_i)
                 + 20'(IP_FLAGS_FRAG)
                 + 20'({Ttl, IP_PROTO_ICMP})
                 + 20'(src_ip_i[31:16])
                 + 20'(src_ip_i[15:0])
                 + 20'(dst_ip_i[31:16])
                 + 20'(dst_ip_i[15:0]);

endmodule

// File: rtl/icmp_reply_framer.sv
// Emits an IPv4 packet (generated header + payload pulled from the echo buffer) as a
// 32-bit valid/ready word stream.
module icmp_reply_framer
    import eth_pkg::*;
#(
    parameter logic [7:0]  TTL       = 8'd64,
    parameter int unsigned HDR_WORDS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_go,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [15:0] i_ident,
    input  logic [7:0]  i_payload_size,
    input  logic [31:0] i_pl_data,
    output logic        o_pl_rd,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_eop,
    input  logic        i_rdy,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [2:0] LastHdr = 3'(HDR_WORDS - 1);

    framer_state_e state_q;
    logic [31:0]   src_q, dst_q, hdr_data_q, hdr_next;
    logic [15:0]   ident_q, total_len_q, csum_q;
    logic [7:0]    size_q, pay_cnt_q;
    logic [2:0]    hdr_cnt_q;
    logic [19:0]   sum_d, sum_q;
    logic          valid_q, sop_q, eop_q, busy_q, done_q;

    ipv4_hdr_csum #(
        .Ttl (TTL)
    ) u_csum (
        .total_len_i (total_len_q),
        .ident_i     (ident_q),
        .src_ip_i    (src_q),
        .dst_ip_i    (dst_q),
        .sum_o       (sum_d)
    );

    // Header word that follows the one currently presented.
    always_comb begin
        hdr_next = dst_q;
        case (hdr_cnt_q)
            3'd0:    hdr_next = {ident_q, IP_FLAGS_FRAG};
            3'd1:    hdr_next = {TTL, IP_PROTO_ICMP, csum_q};
            3'd2:    hdr_next = src_q;
            default: hdr_next = dst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hdr_cnt_q <= 3'd0;
            pay_cnt_q <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_go) begin
                        src_q       <= i_src_ip;
                        dst_q       <= i_dst_ip;
                        ident_q     <= i_ident;
                        size_q      <= i_payload_size;
                        total_len_q <= IPV4_HDR_BYTES + {6'b0, i_payload_size, 2'b00};
                        busy_q      <= 1'b1;
                        state_q     <= StCsum;
                    end
                end
                StCsum: begin
                    sum_q   <= sum_d;
                    state_q <= StFold;
                end
                StFold: begin
                    csum_q     <= ~ones_fold16(sum_q);
                    hdr_data_q <= {IP_VER_IHL, IP_TOS, total_len_q};
                    hdr_cnt_q  <= 3'd0;
                    valid_q    <= 1'b1;
                    sop_q      <= 1'b1;
                    eop_q      <= 1'b0;
                    state_q    <= StHdr;
                end
                StHdr: begin
                    if (i_rdy) begin
                        sop_q <= 1'b0;
                        if (hdr_cnt_q == LastHdr) begin
                            hdr_cnt_q <= 3'd0;
                            if (size_q != 8'd0) begin
                                pay_cnt_q <= 8'd0;
                                eop_q     <= (size_q == 8'd1);
                                state_q   <= StPay;
                            end else begin
                                valid_q <= 1'b0;
                                eop_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end
                        end else begin
                            hdr_cnt_q  <= hdr_cnt_q + 3'd1;
                            hdr_data_q <= hdr_next;
                            eop_q      <= (hdr_cnt_q + 3'd1 == LastHdr) && (size_q == 8'd0);
                        end
                    end
                end
                StPay: begin
                    if (i_rdy) begin
                        if (pay_cnt_q == size_q - 8'd1) begin
                            pay_cnt_q <= 8'd0;
                            valid_q   <= 1'b0;
                            eop_q     <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            pay_cnt_q <= pay_cnt_q + 8'd1;
                            eop_q     <= (pay_cnt_q + 8'd2 == size_q);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Payload words bypass the header register so the buffer needs no extra latency.
    assign o_data  = (state_q == StPay) ? i_pl_data : hdr_data_q;
    assign o_pl_rd = (state_q == StPay) & valid_q & i_rdy;
    assign o_valid = valid_q;
    assign o_sop   = sop_q;
    assign o_eop   = eop_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_icmp_reply_framer.sv
// Bench for icmp_reply_framer: packet-level reference model checked every cycle, plus
// hand-computed header literals for the directed cases.
module tb_icmp_reply_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_go = 1'b0;
    logic        i_rdy = 1'b1;
    logic [31:0] i_src_ip = '0;
    logic [31:0] i_dst_ip = '0;
    logic [15:0] i_ident = '0;
    logic [7:0]  i_payload_size = '0;
    logic [31:0] i_pl_data;
    logic        o_pl_rd, o_valid, o_sop, o_eop, o_busy, o_done;
    logic [31:0] o_data;

    icmp_reply_framer #(
        .TTL       (8'd64),
        .HDR_WORDS (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_go           (i_go),
        .i_src_ip       (i_src_ip),
        .i_dst_ip       (i_dst_ip),
        .i_ident        (i_ident),
        .i_payload_size (i_payload_size),
        .i_pl_data      (i_pl_data),
        .o_pl_rd        (o_pl_rd),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .i_rdy          (i_rdy),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload buffer: zero-latency read, pointer advances on each consume strobe.
    logic [31:0] pl_mem [0:2047];
    logic [10:0] rd_ptr = '0;
    initial begin
        for (int i = 0; i < 2048; i++) pl_mem[i] = 32'h5A000000 ^ (32'(i) * 32'h01030507);
    end
    always @(posedge clk) if (o_pl_rd) rd_ptr <= rd_ptr + 11'd1;
    assign i_pl_data = pl_mem[rd_ptr];

    // Reference model state.
    logic        m_busy = 1'b0, m_active = 1'b0, m_done_due = 1'b0;
    int          m_lat = 0, m_idx = 0, m_len = 0;
    logic [31:0] m_hdr [0:4];
    logic [10:0] mptr = '0;
    logic [31:0] cap [$];
    int          pl_n = 0;

    initial begin
        logic        ev, epl;
        logic [31:0] ew;
        logic [15:0] tl;
        int unsigned s;
        forever begin
            @(negedge clk);
            ev = m_active && (m_lat == 0);
            check("valid", o_valid, ev);
            check("busy", o_busy, m_busy);
            check("done", o_done, m_done_due);
            epl = ev && (m_idx >= 5) && i_rdy;
            check("pl_rd", o_pl_rd, epl);
            if (ev) begin
                ew = (m_idx < 5) ? m_hdr[m_idx] : pl_mem[mptr];
                check("data", o_data, ew);
                check("sop", o_sop, m_idx == 0);
                check("eop", o_eop, m_idx == m_len - 1);
                if (i_rdy) cap.push_back(o_data);
            end
            if (o_pl_rd) pl_n++;
            if (epl) mptr = mptr + 11'd1;
            // Advance to what the coming clock edge does.
            if (rst) begin
                m_busy = 0; m_active = 0; m_done_due = 0; m_lat = 0; m_idx = 0;
            end else if (m_done_due) begin
                m_done_due = 0;
                m_busy     = 0;
            end else if (!m_busy && i_go) begin
                tl = 16'd20 + 16'(i_payload_size) * 16'd4;
                s  = 32'h4500 + tl + i_ident + 32'h4000 + 32'h4001
                   + i_src_ip[31:16] + i_src_ip[15:0] + i_dst_ip[31:16] + i_dst_ip[15:0];
                while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
                m_hdr[0] = {16'h4500, tl};
                m_hdr[1] = {i_ident, 16'h4000};
                m_hdr[2] = {8'd64, 8'h01, ~s[15:0]};
                m_hdr[3] = i_src_ip;
                m_hdr[4] = i_dst_ip;
                m_len    = 5 + int'(i_payload_size);
                m_idx    = 0;
                m_lat    = 2;
                m_active = 1;
                m_busy   = 1;
            end else if (m_active) begin
                if (m_lat > 0) m_lat--;
                else if (i_rdy) begin
                    if (m_idx == m_len - 1) begin
                        m_active   = 0;
                        m_done_due = 1;
                    end else m_idx++;
                end
            end
        end
    end

    // Ready driver: steady high, or the 1-0-0-1 stall pattern.
    logic rdy_mode = 1'b0;
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode) begin
                i_rdy = pat[ph % 4];
                ph++;
            end else i_rdy = 1'b1;
        end
    end

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] id,
                      input logic [7:0] sz);
        @(posedge clk);
        #2;
        i_src_ip = s; i_dst_ip = d; i_ident = id; i_payload_size = sz; i_go = 1'b1;
        @(posedge clk);
        #2;
        i_go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (m_busy && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (k >= budget) check("wait_idle_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic clear_cap();
        cap.delete();
        pl_n = 0;
    endtask

    task automatic check_basic_hdr(input string tag);
        check({tag, "_w0"}, cap[0], 32'h45000024);
        check({tag, "_w1"}, cap[1], 32'h12344000);
        check({tag, "_w2"}, cap[2], 32'h4001A4E6);
        check({tag, "_w3"}, cap[3], 32'hC0A8010A);
        check({tag, "_w4"}, cap[4], 32'hC0A80164);
        check({tag, "_nwords"}, cap.size(), 9);
        check({tag, "_plrd"}, pl_n, 4);
    endtask

    localparam logic [31:0] Src = 32'hC0A8010A;
    localparam logic [31:0] Dst = 32'hC0A80164;

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_plrd", o_pl_rd, 0);
        #1;
        rst = 1'b0;

        // Basic packet with latency and done timing.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd4);
        @(posedge clk); #1;
        check("lat_cycle2_valid", o_valid, 0);
        @(posedge clk); #1;
        check("lat_cycle3_valid", o_valid, 1);
        check("lat_cycle3_sop", o_sop, 1);
        check("lat_cycle3_data", o_data, 32'h45000024);
        cyc = 3;
        while (!o_done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_cycle", cyc, 12);
        wait_idle(50);
        check_basic_hdr("basic");

        // Backpressure.
        clear_cap();
        rdy_mode = 1'b1;
        go(Src, Dst, 16'h1234, 8'd4);
        wait_idle(100);
        rdy_mode = 1'b0;
        check_basic_hdr("bp");

        // size = 0.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd0);
        wait_idle(50);
        check("sz0_w0", cap[0], 32'h45000014);
        check("sz0_w2", cap[2], 32'h4001A4F6);
        check("sz0_w4", cap[4], 32'hC0A80164);
        check("sz0_nwords", cap.size(), 5);
        check("sz0_plrd", pl_n, 0);

        // size = 255.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd255);
        wait_idle(400);
        check("sz255_w0", cap[0], 32'h45000410);
        check("sz255_w2", cap[2], 32'h4001A0FA);
        check("sz255_nwords", cap.size(), 260);
        check("sz255_plrd", pl_n, 255);

        // i_go mid-packet and in the o_done cycle.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd4);
        repeat (3) @(posedge clk);
        #2;
        i_src_ip = 32'h01020304; i_payload_size = 8'd0; i_go = 1'b1;
        @(posedge clk); #2;
        i_go = 1'b0;
        cyc = 0;
        while (!o_done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 40) check("done_wait_timeout", 32'd1, 32'd0);
        #1;
        i_go = 1'b1;
        @(posedge clk); #2;
        i_go = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("ignored_go_busy", o_busy, 0);
        check_basic_hdr("ignored_go");

        // Reset during payload word 2, then a clean packet.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd4);
        cyc = 0;
        while (cap.size() < 7 && cyc < 40) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 40) check("rst_wait_timeout", 32'd1, 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #2;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        repeat (4) @(posedge clk);
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd4);
        wait_idle(50);
        check_basic_hdr("after_rst");

        // Inputs change right after i_go.
        clear_cap();
        go(Src, Dst, 16'h1234, 8'd4);
        i_src_ip = 32'hFFFFFFFF; i_dst_ip = 32'h0; i_ident = 16'hFFFF; i_payload_size = 8'd7;
        wait_idle(50);
        check_basic_hdr("latched");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
